// File: rtl/vdp_tile_fetch.sv
// vdp_tile_fetch: Graphics I scanline fetcher and pixel serialiser for the VDP.
// Define VDP_TEXT_MODE_EN to add the 40-column, 6-pixel text mode.
module vdp_tile_fetch #(
   parameter  int VRAM_SIZE = 8192,
   localparam int AW        = $clog2(VRAM_SIZE)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          line_start,
   input  logic [7:0]    row,
   input  logic          pix_tick,
   input  logic [3:0]    name_base,
   input  logic [7:0]    color_base,
   input  logic [2:0]    pattern_base,
   input  logic [3:0]    backdrop,
`ifdef VDP_TEXT_MODE_EN
   input  logic          text_mode,
   input  logic [3:0]    text_fg,
`endif
   output logic [AW-1:0] dma_addr,
   output logic          dma_rd_tick,
   input  logic [7:0]    vram_dout,
   output logic [3:0]    pix_color,
   output logic          line_done,
   output logic          underrun
);

   typedef enum logic [2:0] {
      IDLE, NAME_RD, NAME_LAT, PAT_RD,
      PAT_LAT, COL_RD, COL_LAT, WAIT
   } state_t;

   state_t        state_q, state_d;
   logic [7:0]    row_q, row_d;
   logic [5:0]    col_q, col_d;
   logic [7:0]    name_q, name_d;
   logic [7:0]    pat_q, pat_d;
   logic [7:0]    bpat_q, bpat_d;
   logic [7:0]    bcol_q, bcol_d;
   logic          bfull_q, bfull_d;
   logic [7:0]    sh_q, sh_d;
   logic [7:0]    ccol_q, ccol_d;
   logic [3:0]    cnt_q, cnt_d;
   logic [5:0]    tiles_q, tiles_d;
   logic          active_q, active_d;
   logic [AW-1:0] addr_q, addr_d;
   logic          rd_q, rd_d;
   logic [3:0]    pix_q, pix_d;
   logic          done_q, done_d;
   logic          urun_q, urun_d;

   logic          txt;
   logic [3:0]    tfg;
   logic [5:0]    ntiles;
   logic [3:0]    tile_w;
   logic [7:0]    sh_v, ccol_v;
   logic [3:0]    cnt_v;
   logic [5:0]    tiles_v;
   logic [3:0]    fg, bg, px;

`ifdef VDP_TEXT_MODE_EN
   assign txt = text_mode;
   assign tfg = text_fg;
`else
   assign txt = 1'b0;
   assign tfg = 4'd0;
`endif

   assign ntiles = txt ? 6'd40 : 6'd32;
   assign tile_w = txt ? 4'd6 : 4'd8;

   always_comb begin
      state_d  = state_q;
      row_d    = row_q;
      col_d    = col_q;
      name_d   = name_q;
      pat_d    = pat_q;
      bpat_d   = bpat_q;
      bcol_d   = bcol_q;
      bfull_d  = bfull_q;
      sh_d     = sh_q;
      ccol_d   = ccol_q;
      cnt_d    = cnt_q;
      tiles_d  = tiles_q;
      active_d = active_q;
      addr_d   = addr_q;
      rd_d     = 1'b0;
      pix_d    = pix_q;
      done_d   = 1'b0;
      urun_d   = urun_q;
      sh_v     = sh_q;
      ccol_v   = ccol_q;
      cnt_v    = cnt_q;
      tiles_v  = tiles_q;
      fg       = 4'd0;
      bg       = 4'd0;
      px       = 4'd0;

      unique case (state_q)
         IDLE:     ;
         NAME_RD:  state_d = NAME_LAT;
         NAME_LAT: begin
            name_d  = vram_dout;
            state_d = PAT_RD;
         end
         PAT_RD:   state_d = PAT_LAT;
         PAT_LAT: begin
            pat_d   = vram_dout;
            state_d = COL_RD;
            if (txt) begin
               bpat_d  = vram_dout;
               bcol_d  = 8'd0;
               bfull_d = 1'b1;
               col_d   = col_q + 6'd1;
               state_d = WAIT;
            end
         end
         COL_RD:   state_d = COL_LAT;
         COL_LAT: begin
            bpat_d  = pat_q;
            bcol_d  = vram_dout;
            bfull_d = 1'b1;
            col_d   = col_q + 6'd1;
            state_d = WAIT;
         end
         WAIT: begin
            if (!bfull_q)
               state_d = (col_q < ntiles) ? NAME_RD : IDLE;
         end
      endcase

      // Loading and emitting in the same clk keeps pixels back-to-back.
      if (cnt_q == 4'd0 && bfull_q) begin
         sh_v    = bpat_q;
         ccol_v  = bcol_q;
         cnt_v   = tile_w;
         tiles_v = tiles_q + 6'd1;
         bfull_d = 1'b0;
      end
      fg = txt ? tfg : ccol_v[7:4];
      bg = txt ? backdrop : ccol_v[3:0];
      px = sh_v[7] ? fg : bg;
      if (pix_tick) begin
         if (cnt_v != 4'd0) begin
            pix_d = (px == 4'd0) ? backdrop : px;
            sh_v  = sh_v << 1;
            cnt_v = cnt_v - 4'd1;
            if (cnt_v == 4'd0 && tiles_v == ntiles) begin
               done_d   = 1'b1;
               active_d = 1'b0;
            end
         end else begin
            pix_d = backdrop;
            if (tiles_v < ntiles && active_q)
               urun_d = 1'b1;
         end
      end
      sh_d    = sh_v;
      ccol_d  = ccol_v;
      cnt_d   = cnt_v;
      tiles_d = tiles_v;

      if (line_start) begin
         state_d  = NAME_RD;
         row_d    = row;
         col_d    = 6'd0;
         bfull_d  = 1'b0;
         cnt_d    = 4'd0;
         tiles_d  = 6'd0;
         active_d = 1'b1;
         urun_d   = 1'b0;
         done_d   = 1'b0;
         pix_d    = pix_tick ? backdrop : pix_q;
      end

      rd_d = (state_d == NAME_RD) || (state_d == PAT_RD) ||
             (state_d == COL_RD);
      // Colour table steps 64 bytes per R3 value; high bits fall off AW.
      unique case (state_d)
         NAME_RD: begin
`ifdef VDP_TEXT_MODE_EN
            if (txt)
               addr_d = AW'({name_base, 10'b0} +
                            14'(row_d[7:3]) * 14'd40 + 14'(col_d));
            else
`endif
               addr_d = AW'({name_base, row_d[7:3], col_d[4:0]});
         end
         PAT_RD:  addr_d = AW'({pattern_base, name_d, row_d[2:0]});
         COL_RD:  addr_d = AW'({color_base, 1'b0, name_d[7:3]});
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         row_q    <= 8'd0;
         col_q    <= 6'd0;
         name_q   <= 8'd0;
         pat_q    <= 8'd0;
         bpat_q   <= 8'd0;
         bcol_q   <= 8'd0;
         bfull_q  <= 1'b0;
         sh_q     <= 8'd0;
         ccol_q   <= 8'd0;
         cnt_q    <= 4'd0;
         tiles_q  <= 6'd0;
         active_q <= 1'b0;
         addr_q   <= '0;
         rd_q     <= 1'b0;
         pix_q    <= 4'd0;
         done_q   <= 1'b0;
         urun_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         row_q    <= row_d;
         col_q    <= col_d;
         name_q   <= name_d;
         pat_q    <= pat_d;
         bpat_q   <= bpat_d;
         bcol_q   <= bcol_d;
         bfull_q  <= bfull_d;
         sh_q     <= sh_d;
         ccol_q   <= ccol_d;
         cnt_q    <= cnt_d;
         tiles_q  <= tiles_d;
         active_q <= active_d;
         addr_q   <= addr_d;
         rd_q     <= rd_d;
         pix_q    <= pix_d;
         done_q   <= done_d;
         urun_q   <= urun_d;
      end
   end

   assign dma_addr    = addr_q;
   assign dma_rd_tick = rd_q;
   assign pix_color   = pix_q;
   assign line_done   = done_q;
   assign underrun    = urun_q;

endmodule

// File: tb/tb_vdp_tile_fetch.sv
// tb_vdp_tile_fetch: directed bench for vdp_tile_fetch with a behavioural
// VRAM that answers dma_rd_tick one clk later.
module tb_vdp_tile_fetch;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        line_start = 1'b0;
   logic [7:0]  row = 8'd0;
   logic        pix_tick = 1'b0;
   logic [3:0]  name_base = 4'd0;
   logic [7:0]  color_base = 8'h80;
   logic [2:0]  pattern_base = 3'd1;
   logic [3:0]  backdrop = 4'd7;
   logic [12:0] dma_addr;
   logic        dma_rd_tick;
   logic [7:0]  vram_dout = 8'd0;
   logic [3:0]  pix_color;
   logic        line_done;
   logic        underrun;

   int checks = 0;
   int errors = 0;

   logic [7:0] mem [0:8191];

   vdp_tile_fetch #(.VRAM_SIZE(8192)) dut (
      .clk          (clk),
      .reset        (reset),
      .line_start   (line_start),
      .row          (row),
      .pix_tick     (pix_tick),
      .name_base    (name_base),
      .color_base   (color_base),
      .pattern_base (pattern_base),
      .backdrop     (backdrop),
      .dma_addr     (dma_addr),
      .dma_rd_tick  (dma_rd_tick),
      .vram_dout    (vram_dout),
      .pix_color    (pix_color),
      .line_done    (line_done),
      .underrun     (underrun)
   );

   always #5 clk = ~clk;

   always @(posedge clk)
      if (dma_rd_tick) vram_dout <= mem[dma_addr];

   // Row 9 line: tile 1 has colour 0 (backdrop 7), tile 31 is solid 2,
   // all other tiles are pattern A5 with colour 4F.
   function automatic logic [3:0] exp_line(input int i);
      logic [31:0] p;
      int          t;
      p = 32'h4F4FF4F4;
      t = i / 8;
      if (i >= 256) return 4'h7;
      if (t == 1)   return 4'h7;
      if (t == 31)  return 4'h2;
      return p[31 - 4 * (i % 8) -: 4];
   endfunction

   task automatic do_ls(input logic [7:0] r);
      @(negedge clk);
      row = r;
      line_start = 1'b1;
      @(negedge clk);
      line_start = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if (dma_rd_tick !== 1'b0) begin
         errors++;
         $display("FAIL reset_rd got %b exp 0", dma_rd_tick);
      end
      checks++;
      if (dma_addr !== 13'h0) begin
         errors++;
         $display("FAIL reset_addr got %h exp 0000", dma_addr);
      end
      checks++;
      if (pix_color !== 4'h0) begin
         errors++;
         $display("FAIL reset_pix got %h exp 0", pix_color);
      end
      checks++;
      if (line_done !== 1'b0) begin
         errors++;
         $display("FAIL reset_done got %b exp 0", line_done);
      end
      checks++;
      if (underrun !== 1'b0) begin
         errors++;
         $display("FAIL reset_underrun got %b exp 0", underrun);
      end
   endtask

   task automatic test_idle;
      backdrop = 4'd5;
      pix_tick = 1'b1;
      @(negedge clk);
      pix_tick = 1'b0;
      checks++;
      if (pix_color !== 4'h5) begin
         errors++;
         $display("FAIL idle_pix got %h exp 5", pix_color);
      end
      checks++;
      if (underrun !== 1'b0) begin
         errors++;
         $display("FAIL idle_underrun got %b exp 0", underrun);
      end
      backdrop = 4'd7;
   endtask

   task automatic test_addresses;
      do_ls(8'd9);
      checks++;
      if (dma_rd_tick !== 1'b1 || dma_addr !== 13'h0020) begin
         errors++;
         $display("FAIL name_rd got %b/%h exp 1/0020", dma_rd_tick, dma_addr);
      end
      @(negedge clk);
      checks++;
      if (dma_rd_tick !== 1'b0) begin
         errors++;
         $display("FAIL name_lat_rd got %b exp 0", dma_rd_tick);
      end
      @(negedge clk);
      checks++;
      if (dma_rd_tick !== 1'b1 || dma_addr !== 13'h0A09) begin
         errors++;
         $display("FAIL pat_rd got %b/%h exp 1/0a09", dma_rd_tick, dma_addr);
      end
      @(negedge clk);
      checks++;
      if (dma_rd_tick !== 1'b0) begin
         errors++;
         $display("FAIL pat_lat_rd got %b exp 0", dma_rd_tick);
      end
      @(negedge clk);
      checks++;
      if (dma_rd_tick !== 1'b1 || dma_addr !== 13'h0008) begin
         errors++;
         $display("FAIL col_rd got %b/%h exp 1/0008", dma_rd_tick, dma_addr);
      end
   endtask

   task automatic test_full_line;
      int ndone;
      ndone = 0;
      do_ls(8'd9);
      repeat (7) @(negedge clk);
      pix_tick = 1'b1;
      for (int i = 0; i < 260; i++) begin
         @(negedge clk);
         if (line_done === 1'b1) ndone++;
         checks++;
         if (pix_color !== exp_line(i)) begin
            errors++;
            $display("FAIL line_pix[%0d] got %h exp %h",
                     i, pix_color, exp_line(i));
         end
         checks++;
         if (line_done !== (i == 255)) begin
            errors++;
            $display("FAIL line_done[%0d] got %b exp %b",
                     i, line_done, (i == 255));
         end
      end
      pix_tick = 1'b0;
      checks++;
      if (underrun !== 1'b0) begin
         errors++;
         $display("FAIL line_underrun got %b exp 0", underrun);
      end
      checks++;
      if (ndone != 1) begin
         errors++;
         $display("FAIL line_done_count got %0d exp 1", ndone);
      end
   endtask

   task automatic test_underrun;
      backdrop = 4'd3;
      do_ls(8'd9);
      @(negedge clk);
      pix_tick = 1'b1;
      @(negedge clk);
      pix_tick = 1'b0;
      checks++;
      if (pix_color !== 4'h3) begin
         errors++;
         $display("FAIL early_pix got %h exp 3", pix_color);
      end
      checks++;
      if (underrun !== 1'b1) begin
         errors++;
         $display("FAIL early_underrun got %b exp 1", underrun);
      end
      repeat (3) @(negedge clk);
      checks++;
      if (underrun !== 1'b1) begin
         errors++;
         $display("FAIL underrun_sticky got %b exp 1", underrun);
      end
      do_ls(8'd9);
      checks++;
      if (underrun !== 1'b0) begin
         errors++;
         $display("FAIL underrun_clear got %b exp 0", underrun);
      end
      backdrop = 4'd7;
   endtask

   task automatic test_restart;
      logic [3:0] e;
      do_ls(8'd9);
      repeat (7) @(negedge clk);
      pix_tick = 1'b1;
      repeat (80) @(negedge clk);
      pix_tick = 1'b0;
      checks++;
      if (pix_color !== exp_line(79)) begin
         errors++;
         $display("FAIL restart_pre got %h exp %h", pix_color, exp_line(79));
      end
      do_ls(8'd17);
      checks++;
      if (dma_rd_tick !== 1'b1 || dma_addr !== 13'h0040) begin
         errors++;
         $display("FAIL restart_addr got %b/%h exp 1/0040",
                  dma_rd_tick, dma_addr);
      end
      repeat (7) @(negedge clk);
      pix_tick = 1'b1;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         e = (i < 8) ? 4'h2 : 4'h7;
         checks++;
         if (pix_color !== e) begin
            errors++;
            $display("FAIL restart_pix[%0d] got %h exp %h", i, pix_color, e);
         end
      end
      pix_tick = 1'b0;
      checks++;
      if (underrun !== 1'b0) begin
         errors++;
         $display("FAIL restart_underrun got %b exp 0", underrun);
      end
   endtask

   initial begin
      for (int a = 0; a < 8192; a++) mem[a] = 8'h00;
      for (int c = 0; c < 32; c++) mem[13'h0020 + c] = 8'h41;
      mem[13'h0021] = 8'h00;
      mem[13'h003F] = 8'h48;
      mem[13'h0A09] = 8'hA5;
      mem[13'h0008] = 8'h4F;
      mem[13'h0801] = 8'hF0;
      mem[13'h0A41] = 8'hFF;
      mem[13'h0009] = 8'h21;
      mem[13'h0040] = 8'h48;

      test_reset();
      test_idle();
      test_addresses();
      test_full_line();
      test_underrun();
      test_restart();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
